// File: rtl/rs_stream_encoder_pkg.sv
// Shared Reed-Solomon helpers: GF(2^m) multiply, generator-polynomial coefficients
// and the encoder state type.
package rs_pkg;

    localparam int SYMBOL_WIDTH = 8;

    typedef logic [SYMBOL_WIDTH-1:0] symbol_t;

    typedef enum logic [0:0] {
        MSG    = 1'b0,
        PARITY = 1'b1
    } state_t;

    function automatic int poly_degree(input logic [31:0] poly);
        int deg;
        deg = 0;
        for (int i = 0; i < 32; i++) begin
            if (poly[i]) deg = i;
        end
        return deg;
    endfunction

    // MSB-first shift-and-add; the product is reduced whenever bit m appears.
    function automatic logic [31:0] gf_mul_f(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] prim);
        logic [31:0] acc;
        int          m;
        m   = poly_degree(prim);
        acc = '0;
        for (int i = 31; i >= 0; i--) begin
            acc = acc << 1;
            if (acc[m]) acc = acc ^ prim;
            if (b[i]) acc = acc ^ a;
        end
        return acc;
    endfunction

    // Builds g(x) = prod (x + alpha^(fcr+i)) one root at a time; g[nk] is the implicit monic term.
    function automatic logic [31:0] gen_poly_coeff(input int idx, input int nk, input int fcr,
                                                   input logic [31:0] prim);
        logic [31:0] g [256];
        logic [31:0] root;
        for (int j = 0; j < 256; j++) g[j] = '0;
        g[0] = 32'd1;
        root = 32'd1;
        for (int k = 0; k < fcr; k++) root = gf_mul_f(root, 32'd2, prim);
        for (int i = 0; i < nk; i++) begin
            for (int j = i + 1; j > 0; j--) g[j] = g[j-1] ^ gf_mul_f(g[j], root, prim);
            g[0] = gf_mul_f(g[0], root, prim);
            root = gf_mul_f(root, 32'd2, prim);
        end
        return g[idx];
    endfunction

endpackage

// File: rtl/rs_stream_encoder_if.sv
// Message-in / codeword-out stream bundle of the RS encoder; master is the
// surrounding framer/serializer side, slave is the encoder.
interface rs_stream_encoder_if #(
    parameter int SYMBOL_WIDTH = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [SYMBOL_WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SYMBOL_WIDTH-1:0] out_data;
    logic                    out_sop;
    logic                    out_eop;
    logic                    out_is_parity;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop, out_is_parity
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop, out_is_parity
    );
endinterface

// File: rtl/rs_stream_encoder_gf_const_mul.sv
// Multiplies a symbol by an elaboration-time constant: each input bit selects a
// precomputed column (2^j * COEFF) and the selected columns are XORed together.
module gf_const_mul
    import rs_pkg::*;
#(
    parameter int          SYMBOL_WIDTH = 8,
    parameter logic [31:0] PRIM_POLY    = 32'h11D,
    parameter logic [31:0] COEFF        = 32'd1
) (
    input  logic [SYMBOL_WIDTH-1:0] a_i,
    output logic [SYMBOL_WIDTH-1:0] p_o
);

    logic [SYMBOL_WIDTH-1:0] terms [SYMBOL_WIDTH];

    for (genvar j = 0; j < SYMBOL_WIDTH; j++) begin : g_col
        localparam logic [SYMBOL_WIDTH-1:0] COL =
            SYMBOL_WIDTH'(gf_mul_f(32'd1 << j, COEFF, PRIM_POLY));
        assign terms[j] = a_i[j] ? COL : '0;
    end

    always_comb begin
        p_o = '0;
        for (int j = 0; j < SYMBOL_WIDTH; j++) begin
            p_o = p_o ^ terms[j];
        end
    end

endmodule

// File: rtl/rs_stream_encoder.sv
// Streaming systematic RS encoder: forwards K message symbols, then drains the
// N-K parity symbols left in the LFSR that divides by the generator polynomial.
module rs_stream_encoder
    import rs_pkg::*;
#(
    parameter int          SYMBOL_WIDTH = 8,
    parameter int          N            = 18,
    parameter int          K            = 16,
    parameter logic [31:0] PRIM_POLY    = 32'h11D,
    parameter int          FCR          = 0
) (
    input logic                clk,
    input logic                rst_n,
    rs_stream_encoder_if.slave bus
);

    localparam int NK     = N - K;
    localparam int MSG_CW = (K > 1) ? $clog2(K) : 1;
    localparam int PAR_CW = (NK > 1) ? $clog2(NK) : 1;
    localparam logic [MSG_CW-1:0] MSG_LAST = MSG_CW'(K - 1);
    localparam logic [PAR_CW-1:0] PAR_LAST = PAR_CW'(NK - 1);

    if (K < 1 || K >= N) begin : g_bad_k
        $error("rs_stream_encoder: K must satisfy 1 <= K < N");
    end
    if (N > (1 << SYMBOL_WIDTH) - 1) begin : g_bad_n
        $error("rs_stream_encoder: N exceeds 2^SYMBOL_WIDTH - 1");
    end
    if (poly_degree(PRIM_POLY) != SYMBOL_WIDTH) begin : g_bad_poly
        $error("rs_stream_encoder: PRIM_POLY MSB must sit at bit SYMBOL_WIDTH");
    end

    state_t                  state_q, state_d;
    logic [MSG_CW-1:0]       msgCnt_q, msgCnt_d;
    logic [PAR_CW-1:0]       parCnt_q, parCnt_d;
    logic [SYMBOL_WIDTH-1:0] par_q [NK];
    logic [SYMBOL_WIDTH-1:0] par_d [NK];
    logic [SYMBOL_WIDTH-1:0] prod  [NK];
    logic [SYMBOL_WIDTH-1:0] feedback;
    logic [SYMBOL_WIDTH-1:0] outData_q, outData_d;
    logic                    outValid_q, outValid_d;
    logic                    outSop_q, outSop_d;
    logic                    outEop_q, outEop_d;
    logic                    outPar_q, outPar_d;
    logic                    slotFree;
    logic                    accept;

    assign feedback = bus.in_data ^ par_q[NK-1];

    for (genvar i = 0; i < NK; i++) begin : g_fb_mul
        gf_const_mul #(
            .SYMBOL_WIDTH (SYMBOL_WIDTH),
            .PRIM_POLY    (PRIM_POLY),
            .COEFF        (gen_poly_coeff(i, NK, FCR, PRIM_POLY))
        ) u_mul (
            .a_i (feedback),
            .p_o (prod[i])
        );
    end

    // The output register frees up when empty or when its symbol leaves this cycle.
    assign slotFree = !outValid_q || bus.out_ready;

    always_comb begin
        state_d      = state_q;
        msgCnt_d     = msgCnt_q;
        parCnt_d     = parCnt_q;
        par_d        = par_q;
        outData_d    = outData_q;
        outValid_d   = outValid_q;
        outSop_d     = outSop_q;
        outEop_d     = outEop_q;
        outPar_d     = outPar_q;
        bus.in_ready = 1'b0;
        accept       = 1'b0;

        case (state_q)
            MSG: begin
                bus.in_ready = slotFree && rst_n;
                accept       = bus.in_valid && slotFree && rst_n;
                if (accept) begin
                    outData_d  = bus.in_data;
                    outValid_d = 1'b1;
                    outPar_d   = 1'b0;
                    outEop_d   = 1'b0;
                    outSop_d   = (msgCnt_q == '0);
                    par_d[0]   = prod[0];
                    for (int i = 1; i < NK; i++) begin
                        par_d[i] = par_q[i-1] ^ prod[i];
                    end
                    if (msgCnt_q == MSG_LAST) begin
                        state_d  = PARITY;
                        msgCnt_d = '0;
                    end else begin
                        msgCnt_d = msgCnt_q + 1'b1;
                    end
                end else if (slotFree) begin
                    outValid_d = 1'b0;
                    outSop_d   = 1'b0;
                    outEop_d   = 1'b0;
                    outPar_d   = 1'b0;
                end
            end
            PARITY: begin
                if (slotFree) begin
                    outData_d  = par_q[NK-1];
                    outValid_d = 1'b1;
                    outPar_d   = 1'b1;
                    outSop_d   = 1'b0;
                    outEop_d   = (parCnt_q == PAR_LAST);
                    par_d[0]   = '0;
                    for (int i = 1; i < NK; i++) begin
                        par_d[i] = par_q[i-1];
                    end
                    if (parCnt_q == PAR_LAST) begin
                        state_d  = MSG;
                        parCnt_d = '0;
                    end else begin
                        parCnt_d = parCnt_q + 1'b1;
                    end
                end
            end
            default: state_d = MSG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= MSG;
            msgCnt_q   <= '0;
            parCnt_q   <= '0;
            for (int i = 0; i < NK; i++) begin
                par_q[i] <= '0;
            end
            outData_q  <= '0;
            outValid_q <= 1'b0;
            outSop_q   <= 1'b0;
            outEop_q   <= 1'b0;
            outPar_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            msgCnt_q   <= msgCnt_d;
            parCnt_q   <= parCnt_d;
            par_q      <= par_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            outSop_q   <= outSop_d;
            outEop_q   <= outEop_d;
            outPar_q   <= outPar_d;
        end
    end

    assign bus.out_valid     = outValid_q;
    assign bus.out_data      = outData_q;
    assign bus.out_sop       = outSop_q;
    assign bus.out_eop       = outEop_q;
    assign bus.out_is_parity = outPar_q;

endmodule
